// File: rtl/eh2_lsu_ecc_scrub.sv
// LSU ECC scrubber: carries DC3 single-bit corrections through DC4/DC5 and writes them
// back to the DCCM with fresh ECC. Define RV_LSU_SCRUB_CNT_EN for the corrected-error counter.

module rvecc_encode (
    input  logic [31:0] din,
    output logic [6:0]  ecc_out
);
    // Hamming check bits over positions 1..38, plus overall parity in bit 6
    assign ecc_out[0] = ^(din & 32'h56AAAD5B);
    assign ecc_out[1] = ^(din & 32'h9B33366D);
    assign ecc_out[2] = ^(din & 32'hE3C3C78E);
    assign ecc_out[3] = ^(din & 32'h03FC07F0);
    assign ecc_out[4] = ^(din & 32'h03FFF800);
    assign ecc_out[5] = ^(din & 32'hFC000000);
    assign ecc_out[6] = ^{din, ecc_out[5:0]};
endmodule

module eh2_lsu_ecc_scrub #(
    parameter int DCCM_BITS        = 16,
    parameter int DCCM_DATA_WIDTH  = 32,
    parameter int DCCM_ECC_WIDTH   = 7,
    parameter int DCCM_FDATA_WIDTH = 39,
    parameter int SCRUB_DEPTH      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ecc_disable,
    input  logic                        err_lo_dc3,
    input  logic                        err_hi_dc3,
    input  logic [DCCM_BITS-1:0]        addr_lo_dc3,
    input  logic [DCCM_BITS-1:0]        addr_hi_dc3,
    input  logic [DCCM_DATA_WIDTH-1:0]  sec_data_lo_dc3,
    input  logic [DCCM_DATA_WIDTH-1:0]  sec_data_hi_dc3,
    input  logic                        kill_dc4,
    input  logic                        kill_dc5,
    output logic                        wr_req,
    input  logic                        wr_gnt,
    output logic [DCCM_BITS-1:0]        wr_addr,
    output logic [DCCM_FDATA_WIDTH-1:0] wr_data,
    output logic                        scrub_full,
    output logic                        scrub_overflow,
    output logic [15:0]                 scrub_err_cnt
);
    localparam int AW  = $clog2(SCRUB_DEPTH);
    localparam int WAW = DCCM_BITS - 2;

    typedef struct packed {
        logic [WAW-1:0]             waddr;
        logic [DCCM_DATA_WIDTH-1:0] data;
    } ent_t;

    // index 0 = lo bank, 1 = hi bank
    logic [1:0]      w_cap_dc3;
    ent_t [1:0]      w_ent_dc3;
    logic [1:0]      r_vld_dc4, r_vld_dc5;
    ent_t [1:0]      r_ent_dc4, r_ent_dc5;
    logic [1:0]      w_push, w_acc;
    logic [1:0]      w_unused_addr_lsb;

    ent_t            r_mem [SCRUB_DEPTH];
    logic [AW:0]     r_wptr, r_rptr;
    logic [AW:0]     w_count, w_free, w_nacc, w_count_nxt;
    logic [AW-1:0]   w_widx_lo, w_widx_hi;
    logic            w_pop, w_drop, w_full_nxt;
    logic            r_full, r_ovf;
    ent_t            w_head;
    logic [DCCM_ECC_WIDTH-1:0] w_ecc;

    assign w_cap_dc3 = {err_hi_dc3, err_lo_dc3} & {2{~ecc_disable}};
    assign w_ent_dc3[0] = {addr_lo_dc3[DCCM_BITS-1:2], sec_data_lo_dc3};
    assign w_ent_dc3[1] = {addr_hi_dc3[DCCM_BITS-1:2], sec_data_hi_dc3};
    assign w_unused_addr_lsb = addr_lo_dc3[1:0] ^ addr_hi_dc3[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_dc4 <= '0;
            r_vld_dc5 <= '0;
        end else begin
            r_vld_dc4 <= w_cap_dc3;
            r_vld_dc5 <= r_vld_dc4 & {2{~kill_dc4}};
        end
    end

    // payload flops only load alongside a valid, so idle cycles don't toggle them
    always_ff @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (w_cap_dc3[b]) r_ent_dc4[b] <= w_ent_dc3[b];
            if (r_vld_dc4[b]) r_ent_dc5[b] <= r_ent_dc4[b];
        end
    end

    assign w_push  = r_vld_dc5 & {2{~kill_dc5}};
    assign w_count = r_wptr - r_rptr;
    assign w_free  = (AW+1)'(SCRUB_DEPTH) - w_count;
    // free space is judged before this cycle's pop; hi loses when only one slot remains
    assign w_acc[0] = w_push[0] & (w_free != '0);
    assign w_acc[1] = w_push[1] & (w_free > (AW+1)'(w_acc[0]));
    assign w_drop   = |(w_push & ~w_acc);
    assign w_nacc   = (AW+1)'(w_acc[0]) + (AW+1)'(w_acc[1]);

    assign wr_req      = (r_wptr != r_rptr);
    assign w_pop       = wr_req & wr_gnt;
    assign w_count_nxt = w_count + w_nacc - (AW+1)'(w_pop);
    assign w_full_nxt  = ((AW+1)'(SCRUB_DEPTH) - w_count_nxt) < (AW+1)'(2);

    assign w_widx_lo = r_wptr[AW-1:0];
    assign w_widx_hi = r_wptr[AW-1:0] + AW'(w_acc[0]);

    always_ff @(posedge clk) begin
        if (w_acc[0]) r_mem[w_widx_lo] <= r_ent_dc5[0];
        if (w_acc[1]) r_mem[w_widx_hi] <= r_ent_dc5[1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_full <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_wptr <= r_wptr + w_nacc;
            r_rptr <= r_rptr + (AW+1)'(w_pop);
            r_full <= w_full_nxt;
            r_ovf  <= w_drop;
        end
    end

    assign w_head = r_mem[r_rptr[AW-1:0]];

    rvecc_encode u_ecc (
        .din     (w_head.data),
        .ecc_out (w_ecc)
    );

    assign wr_addr        = {w_head.waddr, 2'b00};
    assign wr_data        = {w_ecc, w_head.data};
    assign scrub_full     = r_full;
    assign scrub_overflow = r_ovf;

`ifdef RV_LSU_SCRUB_CNT_EN
    logic [15:0] r_err_cnt;
    logic [16:0] w_cnt_sum;

    assign w_cnt_sum = {1'b0, r_err_cnt} + 17'(w_nacc);

    always_ff @(posedge clk) begin
        if (rst) r_err_cnt <= '0;
        else     r_err_cnt <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
    end

    assign scrub_err_cnt = r_err_cnt;
`else
    assign scrub_err_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_eh2_lsu_ecc_scrub.sv
// Directed bench for eh2_lsu_ecc_scrub: latency, dual/kill/disable paths, backpressure,
// overflow, pointer wrap and reset. Counter checks follow RV_LSU_SCRUB_CNT_EN.
module tb_eh2_lsu_ecc_scrub;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ecc_disable = 1'b0;
    logic        err_lo_dc3 = 1'b0, err_hi_dc3 = 1'b0;
    logic [15:0] addr_lo_dc3 = '0, addr_hi_dc3 = '0;
    logic [31:0] sec_data_lo_dc3 = '0, sec_data_hi_dc3 = '0;
    logic        kill_dc4 = 1'b0, kill_dc5 = 1'b0;
    logic        wr_req, wr_gnt = 1'b0;
    logic [15:0] wr_addr;
    logic [38:0] wr_data;
    logic        scrub_full, scrub_overflow;
    logic [15:0] scrub_err_cnt;

    int n_chk = 0;
    int n_err = 0;
    int exp_cnt = 0;
    logic [15:0] wq_addr[$];
    logic [38:0] wq_data[$];

    eh2_lsu_ecc_scrub dut (
        .clk(clk), .rst(rst), .ecc_disable(ecc_disable),
        .err_lo_dc3(err_lo_dc3), .err_hi_dc3(err_hi_dc3),
        .addr_lo_dc3(addr_lo_dc3), .addr_hi_dc3(addr_hi_dc3),
        .sec_data_lo_dc3(sec_data_lo_dc3), .sec_data_hi_dc3(sec_data_hi_dc3),
        .kill_dc4(kill_dc4), .kill_dc5(kill_dc5),
        .wr_req(wr_req), .wr_gnt(wr_gnt), .wr_addr(wr_addr), .wr_data(wr_data),
        .scrub_full(scrub_full), .scrub_overflow(scrub_overflow),
        .scrub_err_cnt(scrub_err_cnt)
    );

    always #5 clk = ~clk;

    // log every granted write
    always @(posedge clk) begin
        if (!rst && wr_req && wr_gnt) begin
            wq_addr.push_back(wr_addr);
            wq_data.push_back(wr_data);
        end
    end

    // SECDED reference built from Hamming positions, skipping the power-of-2 slots
    function automatic logic [6:0] enc(input logic [31:0] d);
        logic [6:0] e = '0;
        int pos = 1;
        for (int i = 0; i < 32; i++) begin
            pos++;
            while ((pos & (pos - 1)) == 0) pos++;
            for (int b = 0; b < 6; b++)
                if (pos[b]) e[b] = e[b] ^ d[i];
        end
        e[6] = ^{d, e[5:0]};
        return e;
    endfunction

    function automatic logic [15:0] cnt_exp();
`ifdef RV_LSU_SCRUB_CNT_EN
        return 16'(exp_cnt);
`else
        return 16'h0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic err3(input logic lo, input logic hi, input logic [15:0] alo, input logic [31:0] dlo,
                        input logic [15:0] ahi, input logic [31:0] dhi);
        err_lo_dc3 = lo; err_hi_dc3 = hi;
        addr_lo_dc3 = alo; sec_data_lo_dc3 = dlo;
        addr_hi_dc3 = ahi; sec_data_hi_dc3 = dhi;
        tick();
        err_lo_dc3 = 1'b0; err_hi_dc3 = 1'b0;
    endtask

    task automatic chk_wr(input string tag, input int i, input logic [15:0] a, input logic [31:0] d);
        if (i < wq_addr.size()) begin
            chk({tag, "_addr"}, wq_addr[i], a);
            chk({tag, "_data"}, wq_data[i], {enc(d), d});
        end else begin
            chk({tag, "_missing"}, wq_addr.size(), i + 1);
        end
    endtask

    task automatic wq_clear();
        wq_addr.delete();
        wq_data.delete();
    endtask

    initial begin
        idle(2);
        rst = 1'b0;
        chk("rst_req", wr_req, 0);
        chk("rst_full", scrub_full, 0);
        chk("rst_ovf", scrub_overflow, 0);
        chk("rst_cnt", scrub_err_cnt, 0);

        // lo-only: request appears 3 clocks after DC3
        wr_gnt = 1'b1;
        err3(1, 0, 16'h0104, 32'hDEADBEEF, 16'h0, 32'h0);
        chk("lo_req_c1", wr_req, 0);
        tick();
        chk("lo_req_c2", wr_req, 0);
        tick();
        chk("lo_req_c3", wr_req, 1);
        chk("lo_addr", wr_addr, 16'h0104);
        chk("lo_data", wr_data, {enc(32'hDEADBEEF), 32'hDEADBEEF});
        tick();
        chk("lo_req_done", wr_req, 0);
        idle(3);
        exp_cnt += 1;
        chk("lo_nwr", wq_addr.size(), 1);
        chk_wr("lo_wr", 0, 16'h0104, 32'hDEADBEEF);
        chk("lo_cnt", scrub_err_cnt, cnt_exp());
        wq_clear();

        // dual error: lo then hi on consecutive cycles
        err3(1, 1, 16'h0204, 32'h11111111, 16'h0208, 32'h22222222);
        idle(2);
        chk("dual_req0", wr_req, 1);
        chk("dual_head0", wr_addr, 16'h0204);
        tick();
        chk("dual_req1", wr_req, 1);
        chk("dual_head1", wr_addr, 16'h0208);
        tick();
        chk("dual_req_done", wr_req, 0);
        idle(2);
        exp_cnt += 2;
        chk("dual_nwr", wq_addr.size(), 2);
        chk_wr("dual_wr0", 0, 16'h0204, 32'h11111111);
        chk_wr("dual_wr1", 1, 16'h0208, 32'h22222222);
        chk("dual_cnt", scrub_err_cnt, cnt_exp());
        wq_clear();

        // kill in DC4
        err3(1, 1, 16'h0300, 32'h33333333, 16'h0304, 32'h44444444);
        kill_dc4 = 1'b1;
        tick();
        kill_dc4 = 1'b0;
        idle(4);
        chk("kill4_nwr", wq_addr.size(), 0);
        chk("kill4_cnt", scrub_err_cnt, cnt_exp());

        // kill in DC5
        err3(1, 0, 16'h0310, 32'h55555555, 16'h0, 32'h0);
        tick();
        kill_dc5 = 1'b1;
        tick();
        kill_dc5 = 1'b0;
        idle(4);
        chk("kill5_nwr", wq_addr.size(), 0);
        chk("kill5_cnt", scrub_err_cnt, cnt_exp());

        // ecc_disable blocks capture but not the queued entry
        wr_gnt = 1'b0;
        err3(1, 0, 16'h0700, 32'h0E0E0E0E, 16'h0, 32'h0);
        ecc_disable = 1'b1;
        err3(1, 1, 16'h0704, 32'h0E1E1E1E, 16'h0708, 32'h0E2E2E2E);
        idle(3);
        wr_gnt = 1'b1;
        idle(4);
        ecc_disable = 1'b0;
        exp_cnt += 1;
        chk("dis_nwr", wq_addr.size(), 1);
        chk_wr("dis_wr", 0, 16'h0700, 32'h0E0E0E0E);
        chk("dis_cnt", scrub_err_cnt, cnt_exp());
        wq_clear();

        // backpressure: three entries fill to the scrub_full threshold
        wr_gnt = 1'b0;
        err3(1, 0, 16'h0400, 32'hA0A0A0A0, 16'h0, 32'h0);
        err3(1, 0, 16'h0404, 32'hA1A1A1A1, 16'h0, 32'h0);
        err3(1, 0, 16'h0408, 32'hA2A2A2A2, 16'h0, 32'h0);
        chk("bp_req", wr_req, 1);
        chk("bp_full1", scrub_full, 0);
        tick();
        chk("bp_full2", scrub_full, 0);
        tick();
        chk("bp_full3", scrub_full, 1);
        chk("bp_head_a", wr_addr, 16'h0400);
        idle(2);
        chk("bp_hold_a", wr_addr, 16'h0400);
        chk("bp_hold_d", wr_data, {enc(32'hA0A0A0A0), 32'hA0A0A0A0});
        chk("bp_hold_full", scrub_full, 1);
        wr_gnt = 1'b1;
        tick();
        chk("bp_full_clr", scrub_full, 0);
        chk("bp_head1", wr_addr, 16'h0404);
        tick();
        chk("bp_head2", wr_addr, 16'h0408);
        tick();
        chk("bp_empty", wr_req, 0);
        exp_cnt += 3;
        chk("bp_nwr", wq_addr.size(), 3);
        chk_wr("bp_wr0", 0, 16'h0400, 32'hA0A0A0A0);
        chk_wr("bp_wr1", 1, 16'h0404, 32'hA1A1A1A1);
        chk_wr("bp_wr2", 2, 16'h0408, 32'hA2A2A2A2);
        chk("bp_cnt", scrub_err_cnt, cnt_exp());
        wq_clear();

        // overflow: dual push with a single free slot drops hi
        wr_gnt = 1'b0;
        err3(1, 0, 16'h0500, 32'hB0B0B0B0, 16'h0, 32'h0);
        err3(1, 0, 16'h0504, 32'hB1B1B1B1, 16'h0, 32'h0);
        err3(1, 0, 16'h0508, 32'hB2B2B2B2, 16'h0, 32'h0);
        err3(1, 1, 16'h050C, 32'hC0C0C0C0, 16'h0510, 32'hC1C1C1C1);
        tick();
        chk("ovf_pre", scrub_overflow, 0);
        tick();
        chk("ovf_pulse", scrub_overflow, 1);
        chk("ovf_full", scrub_full, 1);
        tick();
        chk("ovf_end", scrub_overflow, 0);
        wr_gnt = 1'b1;
        idle(6);
        exp_cnt += 4;
        chk("ovf_nwr", wq_addr.size(), 4);
        chk_wr("ovf_wr0", 0, 16'h0500, 32'hB0B0B0B0);
        chk_wr("ovf_wr3", 3, 16'h050C, 32'hC0C0C0C0);
        chk("ovf_cnt", scrub_err_cnt, cnt_exp());
        wq_clear();

        // back-to-back push/pop pairs walk the pointers around the ring
        for (int i = 0; i < 9; i++)
            err3(1, 0, 16'h0600 + 16'(4 * i), 32'hC0DE0000 + i, 16'h0, 32'h0);
        idle(5);
        exp_cnt += 9;
        chk("wrap_nwr", wq_addr.size(), 9);
        for (int i = 0; i < 9; i++)
            chk_wr($sformatf("wrap_wr%0d", i), i, 16'h0600 + 16'(4 * i), 32'hC0DE0000 + i);
        chk("wrap_cnt", scrub_err_cnt, cnt_exp());
        wq_clear();

        // reset with entries pending drops them all
        wr_gnt = 1'b0;
        err3(1, 0, 16'h0800, 32'hD0D0D0D0, 16'h0, 32'h0);
        err3(1, 0, 16'h0804, 32'hD1D1D1D1, 16'h0, 32'h0);
        err3(1, 0, 16'h0808, 32'hD2D2D2D2, 16'h0, 32'h0);
        idle(2);
        chk("mrst_pre_req", wr_req, 1);
        chk("mrst_pre_full", scrub_full, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt = 0;
        chk("mrst_req", wr_req, 0);
        chk("mrst_full", scrub_full, 0);
        chk("mrst_cnt", scrub_err_cnt, cnt_exp());
        wr_gnt = 1'b1;
        idle(5);
        chk("mrst_nwr", wq_addr.size(), 0);

`ifdef RV_LSU_SCRUB_CNT_EN
        force dut.r_err_cnt = 16'hFFFF;
        #2;
        release dut.r_err_cnt;
        exp_cnt = 16'hFFFF;
`endif
        err3(1, 0, 16'h0900, 32'hE5E5E5E5, 16'h0, 32'h0);
        idle(5);
        chk("sat_nwr", wq_addr.size(), 1);
        chk("sat_cnt", scrub_err_cnt, cnt_exp());

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
